dmem_req_tracker: RTL and testbench

Parametrised outstanding-request tracker between the execution stage and the D-cache port. It accepts load/store requests, assigns each an entry whose index is the D-cache tag, and issues them. It replays NACKed requests up to a configurable limit, matches out-of-order responses by tag and returns load data to write-back. It replaces the single-outstanding D-cache handshake of the current core with N concurrent requests, flush support and replay accounting.

---
 rtl/dmem_tracker_pkg.sv | 20 ++
 rtl/dmem_req_tracker_first_one.sv | 30 +++
 rtl/dmem_req_tracker.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_req_tracker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_tracker_pkg.sv
// rtl/dmem_tracker_pkg.sv - shared types and helpers for the D-cache request tracker
//
// Purpose: entry state encoding, memory command constants and the is_load helper
// used by dmem_req_tracker.
package dmem_tracker_pkg;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_FLIGHT = 2'd2
    } entry_state_t;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;

    function automatic logic is_load(input logic [4:0] cmd);
        return cmd == M_XRD;
    endfunction

endpackage

// File: rtl/dmem_req_tracker_first_one.sv
// rtl/dmem_req_tracker_first_one.sv - lowest-set-bit finder
//
// Purpose: returns the index of the lowest set bit of i_vec and whether any bit is set.
// Ports:
//   i_vec    in  N           candidate vector
//   o_idx    out $clog2(N)   lowest set index (0 when none set)
//   o_found  out 1           at least one bit of i_vec is set
module first_one #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_vec,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    localparam int IDX_W = $clog2(N);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_req_tracker.sv
// rtl/dmem_req_tracker.sv - outstanding-request tracker between execute and the D-cache
//
// Purpose: accepts load/store requests into N_ENTRIES slots, issues them to the D-cache
// using the slot index as tag, replays NACKed requests up to MAX_REPLAY times, matches
// out-of-order responses by tag and returns load data to write-back. FLUSH drops
// pending requests and marks in-flight ones killed.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   FLUSH                       kill all tracked requests
//   REQ_*                       upstream request (valid/ready, addr, data, cmd, rd)
//   DMEM_REQ_*                  D-cache request (valid/ready, addr, data, cmd, tag)
//   DMEM_RESP_*                 D-cache response (valid, tag, nack, has_data, data)
//   WB_VALID/WB_RD/WB_DATA      registered load write-back pulse
//   REPLAY_ABORT                registered pulse: entry exceeded MAX_REPLAY NACKs
//   SPURIOUS_RESP               registered pulse: response hit no in-flight entry
//   OUTSTANDING                 number of non-FREE entries
module dmem_req_tracker
    import dmem_tracker_pkg::*;
#(
    parameter int ADDR_W     = 40,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 8,
    parameter int N_ENTRIES  = 4,
    parameter int MAX_REPLAY = 7
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          FLUSH,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic [ADDR_W-1:0]             REQ_ADDR,
    input  logic [DATA_W-1:0]             REQ_DATA,
    input  logic [4:0]                    REQ_CMD,
    input  logic [4:0]                    REQ_RD,
    output logic                          DMEM_REQ_VALID,
    input  logic                          DMEM_REQ_READY,
    output logic [ADDR_W-1:0]             DMEM_REQ_BITS_ADDR,
    output logic [DATA_W-1:0]             DMEM_REQ_BITS_DATA,
    output logic [4:0]                    DMEM_REQ_CMD,
    output logic [TAG_W-1:0]              DMEM_REQ_BITS_TAG,
    input  logic                          DMEM_RESP_VALID,
    input  logic [TAG_W-1:0]              DMEM_RESP_BITS_TAG,
    input  logic                          DMEM_RESP_BITS_NACK,
    input  logic                          DMEM_RESP_BITS_HAS_DATA,
    input  logic [DATA_W-1:0]             DMEM_RESP_BITS_DATA,
    output logic                          WB_VALID,
    output logic [4:0]                    WB_RD,
    output logic [DATA_W-1:0]             WB_DATA,
    output logic                          REPLAY_ABORT,
    output logic                          SPURIOUS_RESP,
    output logic [$clog2(N_ENTRIES):0]    OUTSTANDING
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    entry_state_t      r_state  [N_ENTRIES];
    logic [ADDR_W-1:0] r_addr   [N_ENTRIES];
    logic [DATA_W-1:0] r_data   [N_ENTRIES];
    logic [4:0]        r_cmd    [N_ENTRIES];
    logic [4:0]        r_rd     [N_ENTRIES];
    logic [3:0]        r_cnt    [N_ENTRIES];
    logic              r_killed [N_ENTRIES];

    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_abort;
    logic              r_spur;

    logic [N_ENTRIES-1:0] w_free_vec;
    logic [N_ENTRIES-1:0] w_pend_vec;
    logic [IDX_W-1:0]     w_alloc_idx;
    logic [IDX_W-1:0]     w_issue_idx;
    logic                 w_any_free;
    logic                 w_any_pend;
    logic                 w_accept;
    logic                 w_issue;
    logic [IDX_W-1:0]     w_resp_idx;
    logic                 w_tag_in_range;
    logic                 w_resp_hit;
    logic                 w_replay_over;
    logic [CNT_W-1:0]     w_outstanding;

    always_comb begin
        w_free_vec    = '0;
        w_pend_vec    = '0;
        w_outstanding = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_free_vec[i] = (r_state[i] == ST_FREE);
            w_pend_vec[i] = (r_state[i] == ST_PEND);
            if (r_state[i] != ST_FREE) begin
                w_outstanding = w_outstanding + CNT_W'(1);
            end
        end
    end

    first_one #(.N(N_ENTRIES)) u_alloc_pick (
        .i_vec   (w_free_vec),
        .o_idx   (w_alloc_idx),
        .o_found (w_any_free)
    );

    first_one #(.N(N_ENTRIES)) u_issue_pick (
        .i_vec   (w_pend_vec),
        .o_idx   (w_issue_idx),
        .o_found (w_any_pend)
    );

    // Handshake outputs depend only on registered state and FLUSH. Allocation picks a
    // FREE entry and issue picks a PEND entry, so they can never collide.
    assign REQ_READY      = w_any_free && !FLUSH;
    assign DMEM_REQ_VALID = w_any_pend && !FLUSH;
    assign w_accept       = REQ_VALID && REQ_READY;
    assign w_issue        = DMEM_REQ_VALID && DMEM_REQ_READY;

    assign DMEM_REQ_BITS_ADDR = w_any_pend ? r_addr[w_issue_idx] : '0;
    assign DMEM_REQ_BITS_DATA = w_any_pend ? r_data[w_issue_idx] : '0;
    assign DMEM_REQ_CMD       = w_any_pend ? r_cmd[w_issue_idx]  : '0;
    assign DMEM_REQ_BITS_TAG  = w_any_pend ? TAG_W'(w_issue_idx) : '0;

    // Tags above the tracker depth must be rejected, not aliased onto a low entry.
    assign w_resp_idx     = DMEM_RESP_BITS_TAG[IDX_W-1:0];
    assign w_tag_in_range = (DMEM_RESP_BITS_TAG >> IDX_W) == '0;
    assign w_resp_hit     = w_tag_in_range && (r_state[w_resp_idx] == ST_FLIGHT);
    assign w_replay_over  = ({1'b0, r_cnt[w_resp_idx]} + 5'd1) > 5'(MAX_REPLAY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_state[i]  <= ST_FREE;
                r_addr[i]   <= '0;
                r_data[i]   <= '0;
                r_cmd[i]    <= '0;
                r_rd[i]     <= '0;
                r_cnt[i]    <= '0;
                r_killed[i] <= 1'b0;
            end
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_abort    <= 1'b0;
            r_spur     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_abort    <= 1'b0;
            r_spur     <= 1'b0;

            if (FLUSH) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (r_state[i] == ST_PEND) begin
                        r_state[i] <= ST_FREE;
                    end else if (r_state[i] == ST_FLIGHT) begin
                        r_killed[i] <= 1'b1;
                    end
                end
            end

            if (w_accept) begin
                r_state[w_alloc_idx]  <= ST_PEND;
                r_addr[w_alloc_idx]   <= REQ_ADDR;
                r_data[w_alloc_idx]   <= REQ_DATA;
                r_cmd[w_alloc_idx]    <= REQ_CMD;
                r_rd[w_alloc_idx]     <= REQ_RD;
                r_cnt[w_alloc_idx]    <= '0;
                r_killed[w_alloc_idx] <= 1'b0;
            end

            if (w_issue) begin
                r_state[w_issue_idx] <= ST_FLIGHT;
            end

            // Response handling comes last so it overrides the flush kill of the same
            // entry: a response in the flush cycle frees it with the kill honoured.
            if (DMEM_RESP_VALID) begin
                if (!w_resp_hit) begin
                    r_spur <= 1'b1;
                end else if (r_killed[w_resp_idx] || FLUSH) begin
                    r_state[w_resp_idx] <= ST_FREE;
                end else if (DMEM_RESP_BITS_NACK) begin
                    if (w_replay_over) begin
                        r_state[w_resp_idx] <= ST_FREE;
                        r_abort             <= 1'b1;
                    end else begin
                        r_cnt[w_resp_idx]   <= r_cnt[w_resp_idx] + 4'd1;
                        r_state[w_resp_idx] <= ST_PEND;
                    end
                end else begin
                    r_state[w_resp_idx] <= ST_FREE;
                    if (is_load(r_cmd[w_resp_idx]) && DMEM_RESP_BITS_HAS_DATA) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd[w_resp_idx];
                        r_wb_data  <= DMEM_RESP_BITS_DATA;
                    end
                end
            end
        end
    end

    assign WB_VALID      = r_wb_valid;
    assign WB_RD         = r_wb_rd;
    assign WB_DATA       = r_wb_data;
    assign REPLAY_ABORT  = r_abort;
    assign SPURIOUS_RESP = r_spur;
    assign OUTSTANDING   = w_outstanding;

endmodule

// File: tb/tb_dmem_req_tracker.sv
// tb/tb_dmem_req_tracker.sv - directed self-checking bench for dmem_req_tracker
module tb_dmem_req_tracker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [39:0] REQ_ADDR;
    logic [63:0] REQ_DATA;
    logic [4:0]  REQ_CMD;
    logic [4:0]  REQ_RD;
    logic        DMEM_REQ_VALID;
    logic        DMEM_REQ_READY;
    logic [39:0] DMEM_REQ_BITS_ADDR;
    logic [63:0] DMEM_REQ_BITS_DATA;
    logic [4:0]  DMEM_REQ_CMD;
    logic [7:0]  DMEM_REQ_BITS_TAG;
    logic        DMEM_RESP_VALID;
    logic [7:0]  DMEM_RESP_BITS_TAG;
    logic        DMEM_RESP_BITS_NACK;
    logic        DMEM_RESP_BITS_HAS_DATA;
    logic [63:0] DMEM_RESP_BITS_DATA;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [63:0] WB_DATA;
    logic        REPLAY_ABORT;
    logic        SPURIOUS_RESP;
    logic [2:0]  OUTSTANDING;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    dmem_req_tracker dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .FLUSH                   (FLUSH),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_ADDR                (REQ_ADDR),
        .REQ_DATA                (REQ_DATA),
        .REQ_CMD                 (REQ_CMD),
        .REQ_RD                  (REQ_RD),
        .DMEM_REQ_VALID          (DMEM_REQ_VALID),
        .DMEM_REQ_READY          (DMEM_REQ_READY),
        .DMEM_REQ_BITS_ADDR      (DMEM_REQ_BITS_ADDR),
        .DMEM_REQ_BITS_DATA      (DMEM_REQ_BITS_DATA),
        .DMEM_REQ_CMD            (DMEM_REQ_CMD),
        .DMEM_REQ_BITS_TAG       (DMEM_REQ_BITS_TAG),
        .DMEM_RESP_VALID         (DMEM_RESP_VALID),
        .DMEM_RESP_BITS_TAG      (DMEM_RESP_BITS_TAG),
        .DMEM_RESP_BITS_NACK     (DMEM_RESP_BITS_NACK),
        .DMEM_RESP_BITS_HAS_DATA (DMEM_RESP_BITS_HAS_DATA),
        .DMEM_RESP_BITS_DATA     (DMEM_RESP_BITS_DATA),
        .WB_VALID                (WB_VALID),
        .WB_RD                   (WB_RD),
        .WB_DATA                 (WB_DATA),
        .REPLAY_ABORT            (REPLAY_ABORT),
        .SPURIOUS_RESP           (SPURIOUS_RESP),
        .OUTSTANDING             (OUTSTANDING)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [4:0] cmd, input logic [4:0] rd,
                             input logic [39:0] addr, input logic [63:0] data);
        REQ_VALID = v;
        REQ_CMD   = cmd;
        REQ_RD    = rd;
        REQ_ADDR  = addr;
        REQ_DATA  = data;
    endtask

    task automatic drive_resp(input logic v, input logic [7:0] tag, input logic nack,
                              input logic has_data, input logic [63:0] data);
        DMEM_RESP_VALID         = v;
        DMEM_RESP_BITS_TAG      = tag;
        DMEM_RESP_BITS_NACK     = nack;
        DMEM_RESP_BITS_HAS_DATA = has_data;
        DMEM_RESP_BITS_DATA     = data;
    endtask

    initial begin
        RST            = 1'b1;
        FLUSH          = 1'b0;
        DMEM_REQ_READY = 1'b0;
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        tick();
        tick();
        RST = 1'b0;

        check("rst_req_ready", REQ_READY, 1);
        check("rst_dmem_valid", DMEM_REQ_VALID, 0);
        check("rst_wb_valid", WB_VALID, 0);
        check("rst_outstanding", OUTSTANDING, 0);
        check("rst_abort", REPLAY_ABORT, 0);
        check("rst_spurious", SPURIOUS_RESP, 0);

        // Two loads, responses in reverse tag order.
        DMEM_REQ_READY = 1'b1;
        drive_req(1'b1, 5'd0, 5'd5, 40'h100, '0);
        tick();
        check("t1_issue0_valid", DMEM_REQ_VALID, 1);
        check("t1_issue0_tag", DMEM_REQ_BITS_TAG, 0);
        check("t1_issue0_addr", DMEM_REQ_BITS_ADDR, 40'h100);
        drive_req(1'b1, 5'd0, 5'd6, 40'h108, '0);
        tick();
        check("t1_issue1_tag", DMEM_REQ_BITS_TAG, 1);
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        tick();
        check("t1_both_flight", DMEM_REQ_VALID, 0);
        check("t1_outstanding", OUTSTANDING, 2);
        drive_resp(1'b1, 8'd1, 1'b0, 1'b1, 64'hBB);
        tick();
        check("t1_wb1_valid", WB_VALID, 1);
        check("t1_wb1_rd", WB_RD, 6);
        check("t1_wb1_data", WB_DATA, 64'hBB);
        drive_resp(1'b1, 8'd0, 1'b0, 1'b1, 64'hAA);
        tick();
        check("t1_wb0_valid", WB_VALID, 1);
        check("t1_wb0_rd", WB_RD, 5);
        check("t1_wb0_data", WB_DATA, 64'hAA);
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        tick();
        check("t1_wb_done", WB_VALID, 0);
        check("t1_outstanding_end", OUTSTANDING, 0);

        // Fill all four entries, free tag 2, reallocate it.
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 5'd0, 5'(10 + i), 40'(16 * i), '0);
            tick();
        end
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        check("t2_full_ready", REQ_READY, 0);
        check("t2_full_outstanding", OUTSTANDING, 4);
        tick();
        drive_resp(1'b1, 8'd2, 1'b0, 1'b1, 64'h22);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t2_ready_after_free", REQ_READY, 1);
        check("t2_outstanding_3", OUTSTANDING, 3);
        check("t2_wb_rd", WB_RD, 12);
        drive_req(1'b1, 5'd0, 5'd20, 40'h200, '0);
        tick();
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        check("t2_realloc_outstanding", OUTSTANDING, 4);
        check("t2_realloc_tag", DMEM_REQ_BITS_TAG, 2);
        check("t2_realloc_addr", DMEM_REQ_BITS_ADDR, 40'h200);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_resp(1'b1, 8'(i), 1'b0, 1'b0, '0);
            tick();
            check("t2_drain_no_wb", WB_VALID, 0);
        end
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t2_drained", OUTSTANDING, 0);

        // Tag 1 NACKed up to the replay limit, then aborted.
        drive_req(1'b1, 5'd0, 5'd7, 40'h400, '0);
        tick();
        drive_req(1'b1, 5'd0, 5'd8, 40'h408, '0);
        tick();
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        tick();
        for (int k = 1; k <= 7; k++) begin
            drive_resp(1'b1, 8'd1, 1'b1, 1'b0, '0);
            tick();
            drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
            check("t3_replay_valid", DMEM_REQ_VALID, 1);
            check("t3_replay_tag", DMEM_REQ_BITS_TAG, 1);
            check("t3_no_abort", REPLAY_ABORT, 0);
            tick();
        end
        drive_resp(1'b1, 8'd1, 1'b1, 1'b0, '0);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t3_abort_pulse", REPLAY_ABORT, 1);
        check("t3_abort_no_wb", WB_VALID, 0);
        check("t3_abort_outstanding", OUTSTANDING, 1);
        check("t3_abort_no_reissue", DMEM_REQ_VALID, 0);
        tick();
        check("t3_abort_clears", REPLAY_ABORT, 0);
        drive_resp(1'b1, 8'd0, 1'b0, 1'b1, 64'h77);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t3_entry0_wb_rd", WB_RD, 7);
        check("t3_drained", OUTSTANDING, 0);

        // FLUSH with entry 0 PEND and entry 1 FLIGHT.
        drive_req(1'b1, 5'd0, 5'd1, 40'h500, '0);
        tick();
        drive_req(1'b1, 5'd0, 5'd2, 40'h508, '0);
        tick();
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        tick();
        drive_resp(1'b1, 8'd0, 1'b0, 1'b0, '0);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        DMEM_REQ_READY = 1'b0;
        drive_req(1'b1, 5'd0, 5'd9, 40'h600, '0);
        tick();
        check("t4_pend0_tag", DMEM_REQ_BITS_TAG, 0);
        check("t4_pend0_valid", DMEM_REQ_VALID, 1);
        FLUSH = 1'b1;
        #1;
        check("t4_flush_blocks_ready", REQ_READY, 0);
        check("t4_flush_blocks_issue", DMEM_REQ_VALID, 0);
        tick();
        FLUSH = 1'b0;
        DMEM_REQ_READY = 1'b1;
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        check("t4_after_flush_outstanding", OUTSTANDING, 1);
        check("t4_pend_dropped", DMEM_REQ_VALID, 0);
        drive_resp(1'b1, 8'd1, 1'b0, 1'b1, 64'h55);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t4_killed_no_wb", WB_VALID, 0);
        check("t4_drained", OUTSTANDING, 0);

        // Spurious responses: FREE entry and out-of-range tag.
        drive_resp(1'b1, 8'd3, 1'b0, 1'b1, 64'h33);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t5_spurious_free", SPURIOUS_RESP, 1);
        check("t5_spurious_no_wb", WB_VALID, 0);
        check("t5_spurious_outstanding", OUTSTANDING, 0);
        tick();
        check("t5_spurious_clears", SPURIOUS_RESP, 0);
        drive_req(1'b1, 5'd0, 5'd4, 40'h700, '0);
        tick();
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        tick();
        drive_resp(1'b1, 8'd4, 1'b0, 1'b1, 64'h44);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t5_spurious_range", SPURIOUS_RESP, 1);
        check("t5_range_keeps_entry", OUTSTANDING, 1);
        drive_resp(1'b1, 8'd0, 1'b0, 1'b0, '0);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t5_drained", OUTSTANDING, 0);

        // Store completes without write-back.
        drive_req(1'b1, 5'd1, 5'd3, 40'h300, 64'hDEAD);
        tick();
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        check("t6_store_cmd", DMEM_REQ_CMD, 1);
        check("t6_store_data", DMEM_REQ_BITS_DATA, 64'hDEAD);
        tick();
        drive_resp(1'b1, 8'd0, 1'b0, 1'b1, 64'h77);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t6_store_no_wb", WB_VALID, 0);
        check("t6_store_freed", OUTSTANDING, 0);

        // Reset mid-flight.
        drive_req(1'b1, 5'd0, 5'd11, 40'h800, '0);
        tick();
        drive_req(1'b1, 5'd0, 5'd12, 40'h808, '0);
        tick();
        drive_req(1'b0, 5'd0, 5'd0, '0, '0);
        RST = 1'b1;
        drive_resp(1'b1, 8'd0, 1'b0, 1'b1, 64'h99);
        tick();
        drive_resp(1'b0, 8'd0, 1'b0, 1'b0, '0);
        check("t6_rst_wb", WB_VALID, 0);
        check("t6_rst_outstanding", OUTSTANDING, 0);
        check("t6_rst_dmem_valid", DMEM_REQ_VALID, 0);
        check("t6_rst_tag", DMEM_REQ_BITS_TAG, 0);
        RST = 1'b0;
        #1;
        check("t6_rst_ready", REQ_READY, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
